execute_stage: RTL

Execute stage of the 5-stage RV32I pipeline: ID/EX pipeline register, operand forwarding muxes driven by the forwarding-control codes, a single-cycle ALU, and the EX/MEM pipeline register. It supplies the execute-stage source register addresses to the forwarding unit and consumes that unit's select codes. It also detects load-use hazards and inserts the required bubble.

---
 rtl/execute_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX register, forwarding muxes, ALU, EX/MEM register.
// Load-use hazards are detected here and turned into a single ID/EX bubble.
module execute_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            freeze,
  input  logic            flush_ex,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_rd_write,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alu_src_imm,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [1:0]      forward_control_src1,
  input  logic [1:0]      forward_control_src2,
  input  logic [XLEN-1:0] rd_data_wb,
  output logic [4:0]      rs1_addr_execute,
  output logic [4:0]      rs2_addr_execute,
  output logic            load_use_stall,
  output logic [XLEN-1:0] alu_result_mem,
  output logic [XLEN-1:0] store_data_mem,
  output logic [4:0]      rd_addr_mem,
  output logic            rd_write_mem,
  output logic            mem_read_mem,
  output logic            mem_write_mem,
  output logic            valid_mem
);

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpSll   = 4'd5,
    OpSrl   = 4'd6,
    OpSra   = 4'd7,
    OpSlt   = 4'd8,
    OpSltu  = 4'd9,
    OpPassB = 4'd10,
    OpAuipc = 4'd11
  } alu_op_e;

  // ID/EX register
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic [4:0]      r_rd_addr;
  logic            r_rd_write;
  logic [3:0]      r_alu_op;
  logic            r_alu_src_imm;
  logic            r_mem_read;
  logic            r_mem_write;

  // EX/MEM register
  logic [XLEN-1:0] r_alu_result_mem;
  logic [XLEN-1:0] r_store_data_mem;
  logic [4:0]      r_rd_addr_mem;
  logic            r_rd_write_mem;
  logic            r_mem_read_mem;
  logic            r_mem_write_mem;
  logic            r_valid_mem;

  logic            w_load_use;
  logic            w_bubble;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b_fwd;
  logic [XLEN-1:0] w_alu_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu_result;

  // Suppressed under freeze so the hazard is re-evaluated once the hold drops.
  assign w_load_use = r_valid & r_mem_read & (r_rd_addr != 5'd0) &
                      ((r_rd_addr == id_rs1_addr) | (r_rd_addr == id_rs2_addr)) &
                      id_valid & ~freeze;
  assign w_bubble   = flush_ex | w_load_use;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rd_addr     <= '0;
      r_rd_write    <= 1'b0;
      r_alu_op      <= '0;
      r_alu_src_imm <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (freeze) begin
      r_valid       <= r_valid;
    end else if (w_bubble) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rd_addr     <= '0;
      r_rd_write    <= 1'b0;
      r_alu_op      <= '0;
      r_alu_src_imm <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else begin
      r_valid       <= id_valid;
      r_pc          <= id_pc;
      r_rs1_data    <= id_rs1_data;
      r_rs2_data    <= id_rs2_data;
      r_imm         <= id_imm;
      r_rs1_addr    <= id_rs1_addr;
      r_rs2_addr    <= id_rs2_addr;
      r_rd_addr     <= id_rd_addr;
      r_rd_write    <= id_rd_write & (id_rd_addr != 5'd0);
      r_alu_op      <= id_alu_op;
      r_alu_src_imm <= id_alu_src_imm;
      r_mem_read    <= id_mem_read;
      r_mem_write   <= id_mem_write;
    end
  end

  always_comb begin
    w_op_a = r_rs1_data;
    case (forward_control_src1)
      2'b01:   w_op_a = r_alu_result_mem;
      2'b10:   w_op_a = rd_data_wb;
      default: w_op_a = r_rs1_data;
    endcase
  end

  always_comb begin
    w_op_b_fwd = r_rs2_data;
    case (forward_control_src2)
      2'b01:   w_op_b_fwd = r_alu_result_mem;
      2'b10:   w_op_b_fwd = rd_data_wb;
      default: w_op_b_fwd = r_rs2_data;
    endcase
  end

  assign w_alu_b = r_alu_src_imm ? r_imm : w_op_b_fwd;
  assign w_shamt = w_alu_b[4:0];

  always_comb begin
    w_alu_result = '0;
    case (r_alu_op)
      OpAdd:   w_alu_result = w_op_a + w_alu_b;
      OpSub:   w_alu_result = w_op_a - w_alu_b;
      OpAnd:   w_alu_result = w_op_a & w_alu_b;
      OpOr:    w_alu_result = w_op_a | w_alu_b;
      OpXor:   w_alu_result = w_op_a ^ w_alu_b;
      OpSll:   w_alu_result = w_op_a << w_shamt;
      OpSrl:   w_alu_result = w_op_a >> w_shamt;
      OpSra:   w_alu_result = $unsigned($signed(w_op_a) >>> w_shamt);
      OpSlt:   w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_alu_b)};
      OpSltu:  w_alu_result = {{(XLEN-1){1'b0}}, w_op_a < w_alu_b};
      OpPassB: w_alu_result = w_alu_b;
      OpAuipc: w_alu_result = r_pc + r_imm;
      default: w_alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_result_mem <= '0;
      r_store_data_mem <= '0;
      r_rd_addr_mem    <= '0;
      r_rd_write_mem   <= 1'b0;
      r_mem_read_mem   <= 1'b0;
      r_mem_write_mem  <= 1'b0;
      r_valid_mem      <= 1'b0;
    end else if (!freeze) begin
      r_alu_result_mem <= w_alu_result;
      r_store_data_mem <= w_op_b_fwd;
      r_rd_addr_mem    <= r_rd_addr;
      r_rd_write_mem   <= r_rd_write & r_valid;
      r_mem_read_mem   <= r_mem_read & r_valid;
      r_mem_write_mem  <= r_mem_write & r_valid;
      r_valid_mem      <= r_valid;
    end
  end

  assign rs1_addr_execute = r_rs1_addr;
  assign rs2_addr_execute = r_rs2_addr;
  assign load_use_stall   = w_load_use;
  assign alu_result_mem   = r_alu_result_mem;
  assign store_data_mem   = r_store_data_mem;
  assign rd_addr_mem      = r_rd_addr_mem;
  assign rd_write_mem     = r_rd_write_mem;
  assign mem_read_mem     = r_mem_read_mem;
  assign mem_write_mem    = r_mem_write_mem;
  assign valid_mem        = r_valid_mem;

endmodule
